// File: rtl/serial_fs.sv
// Bit-serial full subtractor: D = A - B - Bi, one difference bit per clock, LSB first.
// A single subtractor cell plus a borrow flop is reused across WIDTH cycles.
module serial_fs #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sa_q, sb_q, sr_q, d_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, busy_q, done_q, bo_q;

  logic             diff_bit, borrow_d;
  logic [WIDTH-1:0] sr_d;

  // One full-subtractor cell on the current LSBs.
  assign diff_bit = sa_q[0] ^ sb_q[0] ^ br_q;
  assign borrow_d = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  assign sr_d     = {diff_bit, sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sa_q    <= A;
            sb_q    <= B;
            br_q    <= Bi;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= borrow_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CW'(1);
          // Last bit: publish result including the bit computed this edge.
          if (cnt_q == LastCnt) begin
            d_q     <= sr_d;
            bo_q    <= borrow_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign D    = d_q;
  assign Bo   = bo_q;

endmodule

// File: tb/tb_serial_fs.sv
// Scoreboard bench for serial_fs: directed WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
module tb_serial_fs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start8 = 1'b0, start4 = 1'b0;
  logic [7:0] A8 = '0, B8 = '0, D8;
  logic [3:0] A4 = '0, B4 = '0, D4;
  logic       Bi8 = 1'b0, Bi4 = 1'b0;
  logic       busy8, done8, Bo8, busy4, done4, Bo4;

  int errors = 0;
  int checks = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];
  logic       prev_done8 = 1'b0, prev_done4 = 1'b0;

  always #5 clk = ~clk;

  serial_fs #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(A8), .B(B8), .Bi(Bi8),
    .busy(busy8), .done(done8), .D(D8), .Bo(Bo8)
  );

  serial_fs #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(A4), .B(B4), .Bi(Bi4),
    .busy(busy4), .done(done4), .D(D4), .Bo(Bo4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: pop the expected result whenever a DUT presents done.
  always @(negedge clk) begin
    if (done8) begin
      chk("done8_width", {31'd0, prev_done8}, 32'd0);
      if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
      else chk("result8", {23'd0, Bo8, D8}, {23'd0, q8.pop_front()});
    end
    prev_done8 <= done8;
  end

  always @(negedge clk) begin
    if (done4) begin
      chk("done4_width", {31'd0, prev_done4}, 32'd0);
      if (q4.size() == 0) chk("done4_unexpected", 32'd1, 32'd0);
      else chk("result4", {27'd0, Bo4, D4}, {27'd0, q4.pop_front()});
    end
    prev_done4 <= done4;
  end

  // Present operands with start for one accepting edge; caller guarantees busy8=0.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] exp_d, input logic exp_bo);
    A8 = a; B8 = b; Bi8 = bi; start8 = 1'b1;
    q8.push_back({exp_bo, exp_d});
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // Count cycles until done; busy must stay high until then.
  task automatic wait_done8(input int exp_cycles);
    int n = 0;
    while (!done8 && n < 40) begin
      chk("busy8_during_run", {31'd0, busy8}, 32'd1);
      @(posedge clk); #1;
      n++;
    end
    chk("latency8", n, exp_cycles);
    chk("busy8_in_done", {31'd0, busy8}, 32'd0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input logic [7:0] exp_d, input logic exp_bo);
    issue8(a, b, bi, exp_d, exp_bo);
    wait_done8(8);
  endtask

  task automatic chk_reset_state();
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_done8", {31'd0, done8}, 32'd0);
    chk("rst_d8", {24'd0, D8}, 32'd0);
    chk("rst_bo8", {31'd0, Bo8}, 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state();
    chk("rst_busy4", {31'd0, busy4}, 32'd0);
    chk("rst_d4", {27'd0, Bo4, D4}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=8 vectors.
    run8(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
    run8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    run8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
    run8(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);

    // Start while busy must be ignored; D holds the previous result meanwhile.
    issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    A8 = 8'h00; B8 = 8'hFF; start8 = 1'b1;
    chk("hold_d8", {23'd0, Bo8, D8}, {23'd0, 1'b0, 8'hFE});
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(4);
    repeat (12) begin @(posedge clk); #1; end

    // Back-to-back with start held: done pulses 9 cycles apart.
    A8 = 8'h05; B8 = 8'h03; Bi8 = 1'b0; start8 = 1'b1;
    q8.push_back({1'b0, 8'h02});
    @(posedge clk); #1;
    wait_done8(8);
    A8 = 8'h03; B8 = 8'h05;
    q8.push_back({1'b1, 8'hFE});
    @(posedge clk); #1;
    wait_done8(8);
    start8 = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset after the 4th RUN edge aborts with no done.
    issue8(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_state();
    q8.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run8(8'h0A, 8'h03, 1'b0, 8'h07, 1'b0);

    // Exhaustive WIDTH=4 sweep with start held high.
    start4 = 1'b1;
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      logic [4:0] r;
      int n;
      v = 9'(i);
      A4 = v[8:5]; B4 = v[4:1]; Bi4 = v[0];
      r = {1'b0, v[8:5]} - {1'b0, v[4:1]} - {4'd0, v[0]};
      q4.push_back(r);
      @(posedge clk); #1;
      n = 0;
      while (!done4 && n < 20) begin @(posedge clk); #1; n++; end
      chk("latency4", n, 4);
    end
    start4 = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    chk("q8_drained", q8.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
